// File: rtl/hdr_stream_pkg.sv
// Shared types and helpers for the header stream blocks (latch consumer side).
package hdr_stream_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } emit_state_t;

   localparam int DEF_BEAT_BYTES = 4;

   function automatic int num_beats(input int len, input int bytes);
      return (len + bytes - 1) / bytes;
   endfunction

endpackage

// File: rtl/def.svh
// Shared byte-bus macros and the default header length for the header latch datapath.
`ifndef DEF_SVH
`define DEF_SVH

`define BYTE_BUS    logic [7:0]
`define ZERO_BYTE   8'h00
`define TRUE        1'b1
`define FALSE       1'b0
`define HDR_MAX_LEN 10

`endif

// File: rtl/hdr_beat_mux.sv
// Selects beat `beat` from the header buffer; lane 0 is the MSB lane, lanes past the header are zero with keep=0.
`include "def.svh"

module hdr_beat_mux #(
   parameter int HDR_LEN    = 10,
   parameter int BEAT_BYTES = 4,
   parameter int IDX_W      = 2
) (
   input  `BYTE_BUS                hdr [0:HDR_LEN-1],
   input  logic [IDX_W-1:0]        beat,
   output logic [8*BEAT_BYTES-1:0] data,
   output logic [BEAT_BYTES-1:0]   keep
);

   always_comb begin
      data = '0;
      keep = '0;
      for (int j = 0; j < BEAT_BYTES; j++) begin
         data[8*(BEAT_BYTES-j)-1 -: 8] = `ZERO_BYTE;
         for (int i = 0; i < HDR_LEN; i++) begin
            if (int'(beat) * BEAT_BYTES + j == i) begin
               data[8*(BEAT_BYTES-j)-1 -: 8] = hdr[i];
               keep[BEAT_BYTES-1-j]          = `TRUE;
            end
         end
      end
   end

endmodule

// File: rtl/hdr_emitter.sv
// Pops one header from the upstream latch and serializes it as BEAT_BYTES-wide valid/ready beats.
// Optional: define HDR_EMIT_CNT_EN to add pkt_cnt_o, a count of accepted last beats.
`include "def.svh"

module hdr_emitter
   import hdr_stream_pkg::*;
#(
   parameter int HDR_LEN    = `HDR_MAX_LEN,
   parameter int BEAT_BYTES = DEF_BEAT_BYTES
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    empty_i,
   input  `BYTE_BUS                pkt_hdr_i [0:HDR_LEN-1],
   output logic                    rd_o,
   output logic [8*BEAT_BYTES-1:0] data_o,
   output logic [BEAT_BYTES-1:0]   keep_o,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic                    last_o
`ifdef HDR_EMIT_CNT_EN
   ,
   output logic [31:0]             pkt_cnt_o
`endif
);

   localparam int NUM_BEATS = num_beats(HDR_LEN, BEAT_BYTES);
   localparam int IDX_W     = $clog2(NUM_BEATS) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

   emit_state_t             state_q;
   emit_state_t             state_d;
   `BYTE_BUS                buf_q [0:HDR_LEN-1];
   logic [IDX_W-1:0]        idx_q;
   logic [8*BEAT_BYTES-1:0] mux_data;
   logic [BEAT_BYTES-1:0]   mux_keep;
   logic                    accept;

   hdr_beat_mux #(
      .HDR_LEN    (HDR_LEN),
      .BEAT_BYTES (BEAT_BYTES),
      .IDX_W      (IDX_W)
   ) u_beat_mux (
      .hdr  (buf_q),
      .beat (idx_q),
      .data (mux_data),
      .keep (mux_keep)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (rd_o) begin
         state_d = SEND;
      end else if (state_q == SEND && accept && last_o) begin
         state_d = IDLE;
      end
   end

   // A beat transfers on any edge with valid_o && ready_i; once raised, valid_o and the
   // beat contents hold until that edge. rd_o pops the latch on the edge it is high.
   always_comb begin
      valid_o = (state_q == SEND);
      last_o  = valid_o && (idx_q == LAST_IDX);
      data_o  = valid_o ? mux_data : '0;
      keep_o  = valid_o ? mux_keep : '0;
      accept  = valid_o && ready_i;
      rd_o    = !empty_i && rst && (state_q == IDLE || (accept && last_o));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q <= '0;
         for (int i = 0; i < HDR_LEN; i++) buf_q[i] <= `ZERO_BYTE;
      end else if (rd_o) begin
         idx_q <= '0;
         buf_q <= pkt_hdr_i;
      end else if (accept && !last_o) begin
         idx_q <= idx_q + IDX_W'(1);
      end
   end

`ifdef HDR_EMIT_CNT_EN
   logic [31:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (accept && last_o) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign pkt_cnt_o = cnt_q;
`endif

endmodule

// File: doc/hdr_emitter.md
Name: hdr_emitter

Overview:
- Consumer end of the header latch protocol. Pops one header from an upstream header latch using the empty/rd handshake.
- Holds the header in an internal buffer and serializes it onto a BEAT_BYTES-wide valid/ready byte stream toward the deparser/egress.
- Sits directly downstream of the processing-stage latch.

Parameters:
- HDR_LEN, `HDR_MAX_LEN: header length in bytes. Must match the latch array depth.
- BEAT_BYTES, 4: bytes per output beat. Range 1..HDR_LEN.
- NUM_BEATS (localparam), ceil(HDR_LEN/BEAT_BYTES): beats per header.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- empty_i  in  1  latch empty flag. 0 means pkt_hdr_i is valid.
- pkt_hdr_i  in  `BYTE_BUS x HDR_LEN  latch contents, unpacked array [0:HDR_LEN-1].
- rd_o  out  1  pop strobe to the latch, one cycle per header.
- data_o  out  8*BEAT_BYTES  beat data.
- keep_o  out  BEAT_BYTES  byte-valid mask; bit BEAT_BYTES-1 is the MSB lane.
- valid_o  out  1  beat valid.
- ready_i  in  1  downstream accepts the beat.
- last_o  out  1  final beat of the header.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, buffer and beat index cleared.
  - valid_o=0, last_o=0, data_o=0, keep_o=0, rd_o=0.
  - Applies immediately even mid-header. The partial header is dropped and never resumed.
- rd_o is combinational: rd_o = !empty_i && rst && (state==IDLE || (state==SEND && valid_o && ready_i && last_o)).
- On any edge where rd_o=1:
  - buffer <= pkt_hdr_i, beat index <= 0, state <= SEND.
  - The latch clears on that same edge.
- IDLE:
  - valid_o=0.
  - Leave IDLE only on rd_o.
- SEND:
  - valid_o=1. data_o, keep_o and last_o are driven from the registered buffer and beat index.
  - They are held stable while ready_i=0.
  - On valid_o && ready_i with last_o=0: beat index +1.
  - On valid_o && ready_i with last_o=1: if empty_i=0, capture the next header with zero bubble (stay in SEND, index 0); otherwise go to IDLE.
- Latency: a header present at edge n (empty_i=0 in IDLE) is captured at edge n. The first beat has valid_o=1 in cycle n+1. A header takes NUM_BEATS cycles under continuous ready_i.
- Lane mapping: beat k, lane j (j=0 is the MSB lane, data_o[8*BEAT_BYTES-1 -: 8]) carries byte k*BEAT_BYTES+j.
- Padding: lanes with index >= HDR_LEN carry 0x00 with their keep bit 0. All other keep bits are 1.
- last_o = (beat index == NUM_BEATS-1) && valid_o.
- empty_i is ignored outside the rd_o condition. Toggling of empty_i during SEND is harmless.
- Beat index width is $clog2(NUM_BEATS)+1. No wrap occurs within a header.

Optional Feature:
- Macro: HDR_EMIT_CNT_EN.
- Defined: adds output pkt_cnt_o [31:0]. It is reset to 0 and increments on every accepted last beat, wrapping 0xFFFFFFFF to 0. Capture does not affect it.
- Undefined: no pkt_cnt_o port and no counter logic.

Decomposition:
- `BYTE_BUS, `ZERO_BYTE, `TRUE/`FALSE and `HDR_MAX_LEN stay in def.svh.
- Add a shared package hdr_stream_pkg containing:
  - state enum emit_state_t {IDLE, SEND};
  - function num_beats(len, bytes) for the ceil division;
  - the default BEAT_BYTES constant.
- One natural sub-module, hdr_beat_mux: combinational selection of beat k from the buffer, producing data and keep with zero padding.

Test Plan (HDR_LEN=10, BEAT_BYTES=4, NUM_BEATS=3, header bytes 0x00..0x09 equal to their index):
- Single header, ready_i=1:
  - rd_o pulses for 1 cycle.
  - Then 3 consecutive beats: 0x00010203/keep 1111, 0x04050607/1111, 0x08090000/1100 with last_o=1.
  - Then valid_o=0.
- Backpressure: hold ready_i=0 for 5 cycles on beat 1. data_o stays 0x04050607, valid_o stays 1, and the index does not advance.
- Back-to-back: empty_i=0 again when the last beat is accepted. rd_o=1 in that cycle and the next header's beat 0 follows with no idle cycle.
- Reset mid-header: rst=0 during beat 1. valid_o=0 and rd_o=0 immediately. After release, with empty_i=0, the new header starts at beat 0.
- empty_i=1 throughout: rd_o and valid_o stay 0 indefinitely.
- HDR_EMIT_CNT_EN defined: after 3 headers pkt_cnt_o=3. Preload 0xFFFFFFFF (force) and send one header; pkt_cnt_o becomes 0.
